// File: rtl/boot_pkg.sv
// Shared definitions for the flash boot loader: state encoding, default
// address map and watchdog counter width.
package boot_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_GAP_R = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_GAP_W = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  localparam logic [31:0] DEF_SRC_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_DST_BASE = 32'h0000_0000;

  localparam int TO_W = 8;

endpackage

// File: rtl/boot_wdog.sv
// Per-transfer watchdog: counts cycles while enabled and flags expiry when
// the count is about to reach the limit.
module boot_wdog
  import boot_pkg::*;
(
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expire on the cycle whose edge would bring the count up to the limit.
  assign expired = enable && (({1'b0, count_q} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/flash_boot_loader.sv
// Wishbone master copying WORDS words from FLASH to SDRAM after reset while
// holding the CPU in reset. Optional running checksum: define BOOT_CSUM_EN.
module flash_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0]     SRC_BASE   = DEF_SRC_BASE,
  parameter logic [31:0]     DST_BASE   = DEF_DST_BASE,
  parameter logic [15:0]     WORDS      = 16'd1024,
  parameter logic [TO_W-1:0] TIMEOUT    = 8'd64,
  parameter bit              AUTO_START = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_rst_o,
  output logic [15:0] words_done_o,
  output logic [31:0] csum_o
);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q;
  logic [31:0] data_q;
  logic [15:0] words_done_q;
  logic        restart, last_word, rd_ack, wr_ack;
  logic        wdog_clear, wdog_en, wdog_expired;

  assign restart   = ((state_q == ST_IDLE) && (AUTO_START || start_i)) ||
                     (((state_q == ST_DONE) || (state_q == ST_ERR)) && start_i);
  assign last_word = (idx_q == (WORDS - 16'd1));
  assign rd_ack    = (state_q == ST_RD) && m_ack_i && !m_err_i;
  assign wr_ack    = (state_q == ST_WR) && m_ack_i && !m_err_i;

  assign wdog_en    = (state_q == ST_RD) || (state_q == ST_WR);
  assign wdog_clear = (state_d != state_q);

  boot_wdog u_wdog (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .clear      (wdog_clear),
    .enable     (wdog_en),
    .limit      (TIMEOUT),
    .expired    (wdog_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Error beats ack, ack beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (restart) state_d = (WORDS == 16'd0) ? ST_DONE : ST_RD;
      end
      ST_RD: begin
        if (m_err_i)           state_d = ST_ERR;
        else if (m_ack_i)      state_d = ST_GAP_R;
        else if (wdog_expired) state_d = ST_ERR;
      end
      ST_GAP_R: state_d = ST_WR;
      ST_WR: begin
        if (m_err_i)           state_d = ST_ERR;
        else if (m_ack_i)      state_d = ST_GAP_W;
        else if (wdog_expired) state_d = ST_ERR;
      end
      ST_GAP_W: state_d = last_word ? ST_DONE : ST_RD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      idx_q        <= '0;
      data_q       <= '0;
      words_done_q <= '0;
    end else if (restart) begin
      idx_q        <= '0;
      words_done_q <= '0;
    end else begin
      if (rd_ack) data_q <= m_dat_i;
      if (wr_ack) words_done_q <= words_done_q + 16'd1;
      if ((state_q == ST_GAP_W) && !last_word) idx_q <= idx_q + 16'd1;
    end
  end

`ifdef BOOT_CSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      csum_q <= '0;
    end else if (restart) begin
      csum_q <= '0;
    end else if (rd_ack) begin
      csum_q <= csum_q + m_dat_i;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = '0;
`endif

  assign words_done_o = words_done_q;

  always_comb begin
    m_adr_o   = '0;
    m_dat_o   = '0;
    m_sel_o   = '0;
    m_we_o    = 1'b0;
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    cpu_rst_o = 1'b1;
    case (state_q)
      ST_RD: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_sel_o = 4'hF;
        m_adr_o = SRC_BASE + {14'd0, idx_q, 2'b00};
        busy_o  = 1'b1;
      end
      ST_WR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_sel_o = 4'hF;
        m_adr_o = DST_BASE + {14'd0, idx_q, 2'b00};
        m_dat_o = data_q;
        busy_o  = 1'b1;
      end
      ST_GAP_R, ST_GAP_W: busy_o = 1'b1;
      ST_DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
      end
      ST_ERR:  err_o = 1'b1;
      default: ;
    endcase
  end

endmodule
